// File: rtl/cmd_set_wide_value.sv
// Builds a NUM_SLICES*LENGTH_SLICE-bit value from indexed command slices.
// Commits atomically on the last slice; checks ordering and slice timeout.
module cmd_set_wide_value #(
  parameter int LENGTH_HDR = 8,
  parameter int NUM_SLICES = 4,
  parameter logic [LENGTH_HDR-1:0] EFFECT_CMD = 8'hA0,
  parameter logic [NUM_SLICES*(16-LENGTH_HDR)-1:0] DEFAULT_VALUE = '0,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                                  Clk_In,
  input  logic                                  Rst_N,
  input  logic [16:1]                           Cmd_In,
  input  logic                                  Cmd_En,
  output logic [NUM_SLICES*(16-LENGTH_HDR):1]   Output_Valid_Sig,
  output logic                                  Value_Update,
  output logic                                  Seq_Error,
  output logic                                  Busy
);

  localparam int LS    = 16 - LENGTH_HDR;
  localparam int WV    = NUM_SLICES * LS;
  localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int HW    = LENGTH_HDR - IDX_W;
  localparam int TMR_W = (TIMEOUT_CYCLES > 0) ?
                         $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SLICES - 1);
  localparam logic [TMR_W-1:0] TMR_HIT = (TIMEOUT_CYCLES > 0) ?
                                         TMR_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [TMR_W-1:0] TMR_SAT = TMR_W'(TIMEOUT_CYCLES);

  typedef enum logic {
    S_IDLE,
    S_COLLECT
  } state_t;

  state_t                       r_state;
  logic [NUM_SLICES-1:0][LS-1:0] r_shadow;
  logic [WV-1:0]                r_value;
  logic [IDX_W-1:0]             r_exp;
  logic [TMR_W-1:0]             r_timer;
  logic                         r_upd;
  logic                         r_err;

  state_t                       w_state_n;
  logic [NUM_SLICES-1:0][LS-1:0] w_shadow_n;
  logic [WV-1:0]                w_value_n;
  logic [IDX_W-1:0]             w_exp_n;
  logic [TMR_W-1:0]             w_timer_n;
  logic                         w_upd_n;
  logic                         w_err_n;

  logic                         w_hit;
  logic [IDX_W-1:0]             w_idx;
  logic [LS-1:0]                w_pl;
  logic                         w_tmo;

  assign w_hit = Cmd_En &&
                 (Cmd_In[16 -: HW] == EFFECT_CMD[LENGTH_HDR-1 -: HW]);
  assign w_idx = Cmd_In[17-LENGTH_HDR +: IDX_W];
  assign w_pl  = Cmd_In[LS:1];
  assign w_tmo = (TIMEOUT_CYCLES > 0) && (r_timer == TMR_HIT);

  always_comb begin
    w_state_n  = r_state;
    w_shadow_n = r_shadow;
    w_value_n  = r_value;
    w_exp_n    = r_exp;
    w_timer_n  = r_timer;
    w_upd_n    = 1'b0;
    w_err_n    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_timer_n = '0;
        if (w_hit && w_idx == '0) begin
          w_shadow_n[0] = w_pl;
          if (NUM_SLICES == 1) begin
            w_value_n = w_shadow_n;
            w_upd_n   = 1'b1;
          end else begin
            w_exp_n   = IDX_W'(1);
            w_state_n = S_COLLECT;
          end
        end else if (w_hit) begin
          w_err_n = 1'b1;
        end
      end
      S_COLLECT: begin
        if (w_hit && w_idx == r_exp) begin
          w_shadow_n[w_idx] = w_pl;
          w_timer_n = '0;
          if (w_idx == LAST) begin
            w_value_n = w_shadow_n;
            w_upd_n   = 1'b1;
            w_exp_n   = '0;
            w_state_n = S_IDLE;
          end else begin
            w_exp_n = r_exp + IDX_W'(1);
          end
        end else if (w_hit && w_idx == '0) begin
          // Fresh slice 0 restarts the sequence rather than dropping it
          w_err_n       = 1'b1;
          w_shadow_n    = '0;
          w_shadow_n[0] = w_pl;
          w_exp_n       = IDX_W'(1);
          w_timer_n     = '0;
        end else if (w_hit || w_tmo) begin
          w_err_n    = 1'b1;
          w_shadow_n = '0;
          w_exp_n    = '0;
          w_timer_n  = '0;
          w_state_n  = S_IDLE;
        end else if (TIMEOUT_CYCLES > 0 && r_timer != TMR_SAT) begin
          w_timer_n = r_timer + TMR_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge Clk_In or negedge Rst_N) begin
    if (!Rst_N) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_value  <= DEFAULT_VALUE;
      r_exp    <= '0;
      r_timer  <= '0;
      r_upd    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_shadow <= w_shadow_n;
      r_value  <= w_value_n;
      r_exp    <= w_exp_n;
      r_timer  <= w_timer_n;
      r_upd    <= w_upd_n;
      r_err    <= w_err_n;
    end
  end

  assign Output_Valid_Sig = r_value;
  assign Value_Update     = r_upd;
  assign Seq_Error        = r_err;
  assign Busy             = (r_state == S_COLLECT);

endmodule

// File: tb/tb_cmd_set_wide_value.sv
// Bench for cmd_set_wide_value: directed steps plus random strobes,
// checked every clock against a queue-based model of slice collection.
module tb_cmd_set_wide_value;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:1] cmd;
  logic        en;
  logic [32:1] val;
  logic        upd;
  logic        err;
  logic        busy;

  always #5 clk = ~clk;

  cmd_set_wide_value dut (
    .Clk_In           (clk),
    .Rst_N            (rst_n),
    .Cmd_In           (cmd),
    .Cmd_En           (en),
    .Output_Valid_Sig (val),
    .Value_Update     (upd),
    .Seq_Error        (err),
    .Busy             (busy)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  string       m_step = "init";
  byte unsigned m_q[$];
  logic [31:0] m_val = 32'h0;
  bit          m_upd = 1'b0;
  bit          m_err = 1'b0;
  int          m_age = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s/%s: observed %h expected %h", m_step, tag, obs, exp);
    end
  endtask

  // Collected slices live in a queue; a value is the queue once it holds 4
  task automatic model_edge(input bit e, input logic [15:0] c);
    bit hit;
    int idx;
    byte unsigned pl;
    hit = e && (c[15:10] == 6'b101000);
    idx = int'(c[9:8]);
    pl = c[7:0];
    m_upd = 1'b0;
    m_err = 1'b0;
    if (hit) begin
      if (idx == m_q.size()) begin
        m_q.push_back(pl);
        m_age = 0;
        if (m_q.size() == 4) begin
          m_val = {m_q[3], m_q[2], m_q[1], m_q[0]};
          m_upd = 1'b1;
          m_q.delete();
        end
      end else if (idx == 0) begin
        m_err = 1'b1;
        m_q.delete();
        m_q.push_back(pl);
        m_age = 0;
      end else begin
        m_err = 1'b1;
        m_q.delete();
      end
    end else if (m_q.size() > 0) begin
      m_age++;
      if (m_age >= 1000) begin
        m_err = 1'b1;
        m_q.delete();
      end
    end
  endtask

  task automatic check_all();
    check("value", val, m_val);
    check("update", {31'b0, upd}, {31'b0, m_upd});
    check("seqerr", {31'b0, err}, {31'b0, m_err});
    check("busy", {31'b0, busy}, {31'b0, (m_q.size() > 0)});
  endtask

  task automatic tick(input bit e, input logic [15:0] c);
    en  = e;
    cmd = c;
    @(posedge clk);
    #1;
    model_edge(e, c);
    en  = 1'b0;
    cmd = '0;
    check_all();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    cmd   = '0;
    m_step = "reset";
    #200;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    tick(0, 16'h0000);

    m_step = "commit";
    tick(1, 16'hA011);
    tick(1, 16'hA122);
    tick(1, 16'hA233);
    tick(1, 16'hA344);
    check("commit_val", val, 32'h44332211);
    tick(0, 16'h0000);

    m_step = "seqerr";
    tick(1, 16'hA011);
    tick(1, 16'hA122);
    tick(1, 16'hA355);
    tick(1, 16'hA266);
    tick(0, 16'h0000);

    m_step = "timeout";
    tick(1, 16'hA0AA);
    for (int i = 0; i < 1000; i++) tick(0, 16'h0000);
    check("tmo_err", {31'b0, err}, 32'd1);

    m_step = "tmo_win";
    tick(1, 16'hA0AA);
    for (int i = 0; i < 999; i++) tick(0, 16'h0000);
    tick(1, 16'hA1BB);
    check("win_busy", {31'b0, busy}, 32'd1);
    tick(1, 16'hA2CC);
    tick(1, 16'hA3DD);
    check("win_val", val, 32'hDDCCBBAA);

    m_step = "foreign";
    tick(1, 16'hA011);
    tick(1, 16'hD12A);
    tick(1, 16'hA122);
    tick(1, 16'hE123);
    tick(1, 16'hA233);
    tick(1, 16'hA344);
    check("foreign_val", val, 32'h44332211);

    m_step = "random";
    for (int i = 0; i < 400; i++) begin
      int r;
      bit e;
      logic [15:0] c;
      r = int'($urandom_range(0, 9));
      e = (r < 8);
      if (r < 5)
        c = {8'hA0 | 8'(m_q.size()), 8'($urandom)};
      else if (r < 7)
        c = {8'hA0 | 8'($urandom_range(0, 3)), 8'($urandom)};
      else
        c = 16'($urandom);
      tick(e, c);
    end

    m_step = "midreset";
    tick(1, 16'hA011);
    tick(1, 16'hA122);
    rst_n = 1'b0;
    #1;
    m_q.delete();
    m_val = 32'h0;
    m_upd = 1'b0;
    m_err = 1'b0;
    m_age = 0;
    check_all();
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1, 16'hA233);
    check("mid_err", {31'b0, err}, 32'd1);
    tick(0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cmd_set_wide_value.md
Name: cmd_set_wide_value

Overview:
- Parametrised successor to the single-command N-bit value setter.
- Assembles a value wider than one 16-bit command word from NUM_SLICES successive indexed commands.
- Commits the assembled value atomically once the final slice arrives, with sequence checking and an inter-slice timeout.
- Sits on the DIF command bus beside the existing command decoders; drives wide configuration registers such as thresholds and DAC words.

Parameters:
- LENGTH_HDR, 8: header field width, Cmd_In[16:17-LENGTH_HDR]; payload slice width LENGTH_SLICE = 16-LENGTH_HDR.
- NUM_SLICES, 4: slices per value, range 1..16; IDX_W = max(1, clog2(NUM_SLICES)).
- EFFECT_CMD, 8'hA0: header base; its low IDX_W bits must be 0; header low IDX_W bits carry the slice index.
- DEFAULT_VALUE, 0: reset value of Output_Valid_Sig, width WIDTH_VALUE = NUM_SLICES*LENGTH_SLICE.
- TIMEOUT_CYCLES, 1000: maximum clocks between accepted slices; 0 disables the timeout.

Ports:
- Clk_In  in  1: system clock, all logic on the rising edge.
- Rst_N  in  1: asynchronous, active-low reset.
- Cmd_In  in  16: command word, [16:1].
- Cmd_En  in  1: one-cycle strobe, Cmd_In valid while high; each high cycle is one command.
- Output_Valid_Sig  out  WIDTH_VALUE: committed value, [WIDTH_VALUE:1], slice 0 in the LSBs.
- Value_Update  out  1: one-cycle pulse on commit.
- Seq_Error  out  1: one-cycle pulse on sequence error or timeout.
- Busy  out  1: high while a sequence is partially collected.

Behaviour:
- Reset (async assert, sync release):
  - Output_Valid_Sig = DEFAULT_VALUE.
  - Value_Update, Seq_Error, Busy = 0.
  - Shadow register, expected index and timer cleared; state IDLE.
- Match definition: Cmd_En=1 and Cmd_In[16:17-LENGTH_HDR+IDX_W] equals the upper LENGTH_HDR-IDX_W bits of EFFECT_CMD.
  - idx = Cmd_In[17-LENGTH_HDR+IDX_W-1 : 17-LENGTH_HDR].
  - Payload = Cmd_In[LENGTH_SLICE:1].
  - Non-matching strobes are ignored in all states and do not touch the timer.
- IDLE:
  - Match with idx=0: payload goes to shadow slice 0, expected=1, go to COLLECT, Busy=1.
  - If NUM_SLICES=1, commit immediately instead.
  - Match with idx≠0: Seq_Error pulse, stay in IDLE.
- COLLECT:
  - Match with idx=expected: store the slice, reset the timer, expected+1.
  - If idx=NUM_SLICES-1, commit and return to IDLE.
  - Match with idx=0: Seq_Error pulse; restart with this slice 0, expected=1; stay in COLLECT.
  - Match with any other idx (including idx≥NUM_SLICES): Seq_Error pulse, discard the shadow, go to IDLE.
- Commit:
  - Output_Valid_Sig loads {final slice, shadow slices NUM_SLICES-2..0}.
  - Value_Update=1 in the cycle after the final strobe (1-clock latency); Busy=0 in the same cycle.
  - Output holds until the next commit; never partially updated.
- Timeout:
  - In COLLECT the timer increments each clock without an accepted slice.
  - When the timer reaches TIMEOUT_CYCLES: Seq_Error pulse, discard the shadow, go to IDLE.
  - Timer width = clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
  - A slice accepted on the timeout cycle wins: the slice is taken and no error is raised.
- Back-to-back strobes on consecutive clocks are fully supported; no stall.
- Reset mid-sequence aborts the sequence. Output returns to DEFAULT_VALUE with no Value_Update pulse.

Test Plan:
- Defaults (headers A0..A3). Rst_N low 200 ns, then released -> Output_Valid_Sig=32'h00000000, Busy=0, no pulses.
- Strobes A011, A122, A233, A344 on consecutive clocks -> Output_Valid_Sig=32'h44332211, one Value_Update pulse one clock after A344, Busy low on the same clock.
- A011, A122, then A355 -> Seq_Error pulse, Output unchanged, Busy=0. A subsequent A266 in IDLE -> another Seq_Error.
- A0AA, then no strobes -> Busy=1 for 1000 clocks, then Seq_Error pulse and Busy=0. Repeat with A1BB arriving exactly at clock 1000 -> accepted, no error.
- A011, D12A, A122, E123, A233, A344 -> foreign commands ignored, Output=32'h44332211.
- A011, A122, Rst_N pulsed low, then A233 -> Output=DEFAULT_VALUE, Seq_Error pulse on A233, no Value_Update.
